// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and helpers for the SIPO deserializer
//
// Purpose : state encoding, frame length derivation and the even-parity helper.
// Macro   : SIPO_PARITY_EN adds one even-parity bit to every frame.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bits per frame on the wire: data bits plus an optional parity bit.
  function automatic int frame_len(input int width);
`ifdef SIPO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Parity bit that makes the total number of ones (data + parity) even.
  // Callers zero-extend their data; words wider than 64 bits are not supported.
  function automatic logic even_parity(input logic [63:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// rtl/sipo_out_buf.sv - one-entry valid/ready holding register for completed words
//
// Purpose : holds the last completed word until the consumer takes it.
// Ports   : clk, reset_n    - clock, asynchronous active-low reset
//           load            - a good word has just completed
//           word            - the completed word
//           ready           - consumer accepts data_out this cycle
//           data_out        - held word (kept after consumption)
//           data_valid      - data_out holds an unconsumed word
//           overrun         - one-cycle pulse: word dropped because buffer full
module sipo_out_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        // A consumer taking the old word in the same cycle frees the slot.
        if (!data_valid || ready) begin
          data_out   <= word;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in parallel-out receiver for MSB-first words
//
// Purpose : reassembles strobed serial bits into WIDTH-bit words, with frame
//           sync realignment and a one-entry valid/ready output buffer.
// Macro   : SIPO_PARITY_EN - frames carry a trailing even-parity bit; words
//           with a parity mismatch are dropped and parity_err pulses.
// Ports   : clk, reset_n    - clock, asynchronous active-low reset
//           serial_in       - serial data bit, MSB first
//           serial_valid    - qualifies serial_in
//           sync            - current bit (if valid) starts a new word
//           data_out        - last completed word
//           data_valid      - data_out holds an unconsumed word
//           data_ready      - consumer accepts data_out
//           busy            - partial word in progress
//           overrun         - one-cycle pulse: word dropped, buffer full
//           parity_err      - one-cycle pulse: parity mismatch, word dropped
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;
  logic             complete;
  logic             load;
  logic [WIDTH-1:0] word;

  // The cast keeps the low WIDTH bits, i.e. {shift_reg[WIDTH-2:0], serial_in}.
  assign shifted  = WIDTH'({shift_reg, serial_in});
  assign last_bit = (bit_cnt == LAST_CNT);
  // sync wins over completion: a frame cut by sync never emits.
  assign complete = serial_valid && !sync && last_bit;
  assign busy     = (state == SHIFT);

`ifdef SIPO_PARITY_EN
  // The final bit is parity, so the data word is already fully in shift_reg.
  logic parity_ok;
  logic parity_err_q;

  assign word       = shift_reg;
  assign parity_ok  = (even_parity(64'(shift_reg)) == serial_in);
  assign load       = complete && parity_ok;
  assign parity_err = parity_err_q;
`else
  assign word       = shifted;
  assign load       = complete;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef SIPO_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
`ifdef SIPO_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (sync) begin
        if (serial_valid) begin
          shift_reg <= WIDTH'(serial_in);
          bit_cnt   <= CNT_W'(1);
          state     <= SHIFT;
        end else begin
          shift_reg <= '0;
          bit_cnt   <= '0;
          state     <= IDLE;
        end
      end else if (serial_valid) begin
        if (last_bit) begin
          bit_cnt <= '0;
          state   <= IDLE;
`ifdef SIPO_PARITY_EN
          // Parity bit is checked, not stored.
          parity_err_q <= !parity_ok;
`else
          shift_reg <= shifted;
`endif
        end else begin
          bit_cnt   <= bit_cnt + CNT_W'(1);
          state     <= SHIFT;
          shift_reg <= shifted;
        end
      end
    end
  end

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .word      (word),
    .ready     (data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .overrun   (overrun)
  );

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out receiver that reassembles MSB-first serial words back into WIDTH-bit parallel words. It sits at the receive end of the team's PISO serial link: a bit-strobe qualifies each incoming bit, and a frame-sync resets alignment. A one-entry output buffer with valid/ready handshake presents each completed word to the downstream consumer.

## Interface
- WIDTH, 4, parallel word width in bits (≥2)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- serial_in  input  1  serial data bit, MSB of each word first
- serial_valid  input  1  qualifies serial_in; one bit accepted per cycle when high
- sync  input  1  frame start; the current bit, if valid, is bit 0 of a new word
- data_out  output  WIDTH  last completed word
- data_valid  output  1  data_out holds an unconsumed word
- data_ready  input  1  consumer accepts data_out when data_valid & data_ready
- busy  output  1  partial word in progress (state SHIFT)
- overrun  output  1  one-cycle pulse: completed word dropped, buffer full
- parity_err  output  1  one-cycle pulse: parity mismatch, word dropped (tied 0 without SIPO_PARITY_EN)

## Operation
- Shift register: on accepted bit, shift_reg <= {shift_reg[WIDTH-2:0], serial_in}.
- Bit counter bit_cnt, 0..FRAME_LEN-1; FRAME_LEN = WIDTH (WIDTH+1 with parity).
- FSM: IDLE (bit_cnt==0, no partial word) and SHIFT (1 ≤ bit_cnt ≤ FRAME_LEN-1).
  - IDLE -> SHIFT on accepted bit.
  - SHIFT -> IDLE on accepted last bit (word complete); counter wraps to 0.
- Without serial_valid, the counter and shift register hold; gaps of any length are allowed.
- Word complete: the word is {shift_reg[WIDTH-2:0], serial_in}, or the stored WIDTH bits when parity is enabled.
  - Buffer empty, or data_ready high in the same cycle: load data_out and set data_valid.
  - Buffer full and data_ready low: drop the new word, keep the old word, pulse overrun.
- Consumption: data_valid & data_ready with no simultaneous completion clears data_valid. data_out keeps its value.
- sync & serial_valid: discard any partial word; the current bit becomes bit 0 and bit_cnt becomes 1.
- sync alone: discard the partial word; bit_cnt and shift_reg go to 0; state goes to IDLE.
- sync has priority over word completion.

## Timing
- Reset values: data_out=0, data_valid=0, busy=0, overrun=0, parity_err=0, shift_reg=0, bit_cnt=0, state IDLE.
- Reset is asynchronous and clears everything immediately. A partial word in flight is lost.
- Latency: data_valid rises on the clock edge that samples the last bit. It is visible the cycle after that bit is presented.
- overrun and parity_err are registered and high for exactly one cycle.
- Throughput: one word per FRAME_LEN cycles with continuous serial_valid. No bubble is needed at the word boundary.

## Configuration
- SIPO_PARITY_EN defined:
  - Each frame carries one extra even-parity bit after the WIDTH data bits.
  - The parity bit is not stored.
  - On mismatch, the word is dropped, parity_err pulses, and overrun is not raised.
- SIPO_PARITY_EN undefined:
  - FRAME_LEN = WIDTH.
  - parity_err is constant 0.

## Structure
- Package sipo_pkg holds:
  - the state enum (IDLE, SHIFT)
  - the FRAME_LEN derivation
  - the even-parity function
- Sub-module sipo_out_buf: one-entry valid/ready holding register. It drives data_out, data_valid and overrun.
- The top level holds the FSM, counter, shift register and parity check.

## Test plan
- WIDTH=4, reset, data_ready=1, bits 1,0,1,1 on consecutive cycles -> data_out=4'b1011; data_valid high one cycle after the 4th bit, low the next cycle.
- data_ready=0, send 1011 then 0110 -> data_out stays 1011; overrun pulses once when the second word completes; data_ready=1 then clears data_valid.
- Bits 0,1 then 3 idle cycles then 1,0 -> data_out=4'b0110; busy high through the gap.
- Bits 1,1, then sync with bit 0, then 1,0,1 -> data_out=4'b0101; no word emitted for the discarded 1,1.
- Bits 1,1, then reset_n low mid-word -> all outputs 0 immediately; the next 4 bits 1,1,0,0 yield 4'b1100 cleanly.
- SIPO_PARITY_EN: bits 1,0,1,1 with parity 1 -> 4'b1011 valid. Same data with parity 0 -> parity_err pulse, data_valid stays low.
